// File: rtl/mem_dma_master_pkg.sv
// Shared constants for the DMA copy/fill engine: register map, CTRL bits, FSM encoding.
package mem_dma_master_pkg;

  localparam logic [15:0] DMA_BASE_ADDR = 16'hFD10;

  localparam logic [3:0] DMA_SRC_L = 4'h0;
  localparam logic [3:0] DMA_SRC_M = 4'h1;
  localparam logic [3:0] DMA_SRC_H = 4'h2;
  localparam logic [3:0] DMA_DST_L = 4'h3;
  localparam logic [3:0] DMA_DST_M = 4'h4;
  localparam logic [3:0] DMA_DST_H = 4'h5;
  localparam logic [3:0] DMA_LEN_L = 4'h6;
  localparam logic [3:0] DMA_LEN_H = 4'h7;
  localparam logic [3:0] DMA_CTRL  = 4'h8;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_FILL   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_ABORT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_REL  = 3'd4
  } dma_state_e;

  // CTRL read layout: {busy, done, aborted, 2'b0, irq_en, fill, 1'b0}
  function automatic logic [7:0] ctrl_status(input logic busy, input logic done,
                                             input logic aborted, input logic irq_en,
                                             input logic fill);
    return {busy, done, aborted, 2'b00, irq_en, fill, 1'b0};
  endfunction

endpackage

// File: rtl/dma_regfile.sv
// CPU register window for the DMA engine: address decode, SRC/DST/LEN counters, read mux.
module dma_regfile
  import mem_dma_master_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DMA_BASE_ADDR,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [15:0]           i_addr,
  input  logic                  i_r_w,
  input  logic [7:0]            i_wdata,
  input  logic                  i_busy,
  input  logic                  i_src_inc,
  input  logic                  i_dst_inc,
  input  logic                  i_len_dec,
  input  logic [7:0]            i_ctrl_rdata,
  output logic                  o_cpu_sel,
  output logic [7:0]            o_rdata,
  output logic                  o_ctrl_wr,
  output logic                  o_ctrl_rd,
  output logic [ADDR_WIDTH-1:0] o_src,
  output logic [ADDR_WIDTH-1:0] o_dst,
  output logic [LEN_WIDTH-1:0]  o_len
);

  localparam int unsigned HI_W = ADDR_WIDTH - 16;

  logic                  w_hit;
  logic [3:0]            w_off;
  logic                  w_wr;
  logic [7:0]            w_rdata;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0]  r_len;

  assign w_hit     = (i_addr[15:4] == BASE_ADDR[15:4]);
  assign w_off     = i_addr[3:0];
  assign w_wr      = w_hit & ~i_r_w & ~i_busy;
  assign o_cpu_sel = w_hit & i_r_w;
  assign o_ctrl_wr = w_hit & ~i_r_w & (w_off == DMA_CTRL);
  assign o_ctrl_rd = o_cpu_sel & (w_off == DMA_CTRL);
  assign o_src     = r_src;
  assign o_dst     = r_dst;
  assign o_len     = r_len;
  assign o_rdata   = w_rdata;

  // CPU byte loads only while idle; the engine steps the counters while busy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
    end else if (w_wr) begin
      case (w_off)
        DMA_SRC_L: r_src[7:0]             <= i_wdata;
        DMA_SRC_M: r_src[15:8]            <= i_wdata;
        DMA_SRC_H: r_src[ADDR_WIDTH-1:16] <= i_wdata[HI_W-1:0];
        DMA_DST_L: r_dst[7:0]             <= i_wdata;
        DMA_DST_M: r_dst[15:8]            <= i_wdata;
        DMA_DST_H: r_dst[ADDR_WIDTH-1:16] <= i_wdata[HI_W-1:0];
        DMA_LEN_L: r_len[7:0]             <= i_wdata;
        DMA_LEN_H: r_len[LEN_WIDTH-1:8]   <= i_wdata[LEN_WIDTH-9:0];
        default: ;
      endcase
    end else begin
      if (i_src_inc) r_src <= r_src + ADDR_WIDTH'(1);
      if (i_dst_inc) r_dst <= r_dst + ADDR_WIDTH'(1);
      if (i_len_dec) r_len <= r_len - LEN_WIDTH'(1);
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    if (o_cpu_sel) begin
      case (w_off)
        DMA_SRC_L: w_rdata = r_src[7:0];
        DMA_SRC_M: w_rdata = r_src[15:8];
        DMA_SRC_H: w_rdata = 8'(r_src[ADDR_WIDTH-1:16]);
        DMA_DST_L: w_rdata = r_dst[7:0];
        DMA_DST_M: w_rdata = r_dst[15:8];
        DMA_DST_H: w_rdata = 8'(r_dst[ADDR_WIDTH-1:16]);
        DMA_LEN_L: w_rdata = r_len[7:0];
        DMA_LEN_H: w_rdata = 8'(r_len[LEN_WIDTH-1:8]);
        DMA_CTRL:  w_rdata = i_ctrl_rdata;
        default:   w_rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/mem_dma_master.sv
// DMA copy/fill engine mastering the expansion SRAM while the 6809 is halted.
module mem_dma_master
  import mem_dma_master_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DMA_BASE_ADDR,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  e,
  input  logic                  _reset,
  input  logic [15:0]           address_cpu,
  input  logic                  r_w_cpu,
  input  logic [7:0]            data_cpu_in,
  output logic [7:0]            data_cpu_out,
  output logic                  cpu_sel,
  output logic                  _halt,
  input  logic                  ba,
  output logic                  mem_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic                  _mem_we,
  output logic                  irq
);

  dma_state_e            r_state;
  dma_state_e            w_next;
  logic [7:0]            r_data;
  logic                  r_fill;
  logic                  r_irq_en;
  logic                  r_done;
  logic                  r_aborted;
  logic                  r_abort_pend;
  logic                  w_busy;
  logic                  w_ctrl_wr;
  logic                  w_ctrl_rd;
  logic                  w_start;
  logic                  w_abort_now;
  logic                  w_abort;
  logic                  w_enter_rel;
  logic                  w_src_inc;
  logic                  w_dst_inc;
  logic                  w_len_dec;
  logic                  w_latch;
  logic [ADDR_WIDTH-1:0] w_src;
  logic [ADDR_WIDTH-1:0] w_dst;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [7:0]            w_ctrl_rdata;

  assign w_busy       = (r_state != ST_IDLE);
  assign w_start      = w_ctrl_wr & data_cpu_in[CTRL_START] & ~w_busy;
  assign w_abort_now  = w_ctrl_wr & data_cpu_in[CTRL_ABORT] & w_busy;
  assign w_abort      = r_abort_pend | w_abort_now;
  assign w_enter_rel  = (w_next == ST_REL) && (r_state != ST_REL);
  assign w_ctrl_rdata = ctrl_status(w_busy, r_done, r_aborted, r_irq_en, r_fill);
  assign irq          = r_done & r_irq_en;

  dma_regfile #(
    .BASE_ADDR  (BASE_ADDR),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_regfile (
    .i_clk        (e),
    .i_rst_n      (_reset),
    .i_addr       (address_cpu),
    .i_r_w        (r_w_cpu),
    .i_wdata      (data_cpu_in),
    .i_busy       (w_busy),
    .i_src_inc    (w_src_inc),
    .i_dst_inc    (w_dst_inc),
    .i_len_dec    (w_len_dec),
    .i_ctrl_rdata (w_ctrl_rdata),
    .o_cpu_sel    (cpu_sel),
    .o_rdata      (data_cpu_out),
    .o_ctrl_wr    (w_ctrl_wr),
    .o_ctrl_rd    (w_ctrl_rd),
    .o_src        (w_src),
    .o_dst        (w_dst),
    .o_len        (w_len)
  );

  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Every state holds while ba is low; a stalled WR keeps its write pending
  always_comb begin
    w_next    = r_state;
    w_src_inc = 1'b0;
    w_dst_inc = 1'b0;
    w_len_dec = 1'b0;
    w_latch   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start && (w_len != '0)) w_next = ST_REQ;
      ST_REQ: begin
        if (w_abort)  w_next = ST_REL;
        else if (ba)  w_next = r_fill ? ST_WR : ST_RD;
      end
      ST_RD: begin
        if (w_abort) w_next = ST_REL;
        else if (ba) begin
          w_latch = 1'b1;
          w_next  = ST_WR;
        end
      end
      ST_WR: begin
        if (ba) begin
          w_len_dec = 1'b1;
          w_dst_inc = 1'b1;
          w_src_inc = ~r_fill;
          if (w_abort || (w_len == LEN_WIDTH'(1))) w_next = ST_REL;
          else                                     w_next = r_fill ? ST_WR : ST_RD;
        end
      end
      ST_REL:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    _halt    = 1'b1;
    mem_busy = 1'b0;
    mem_addr = '0;
    mem_dout = 8'h00;
    _mem_we  = 1'b1;
    case (r_state)
      ST_REQ: _halt = 1'b0;
      ST_RD: begin
        _halt    = 1'b0;
        mem_busy = 1'b1;
        mem_addr = w_src;
      end
      ST_WR: begin
        _halt    = 1'b0;
        mem_busy = 1'b1;
        mem_addr = w_dst;
        mem_dout = r_fill ? w_src[7:0] : r_data;
        _mem_we  = ~ba;
      end
      default: ;
    endcase
  end

  // Flag set on entering REL is ordered last so a coincident CTRL read cannot lose it
  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      r_data       <= 8'h00;
      r_fill       <= 1'b0;
      r_irq_en     <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_latch) r_data <= mem_din;
      if (w_ctrl_wr) begin
        r_irq_en <= data_cpu_in[CTRL_IRQ_EN];
        if (!w_busy) r_fill <= data_cpu_in[CTRL_FILL];
      end
      if (r_state == ST_REL) r_abort_pend <= 1'b0;
      else if (w_abort_now)  r_abort_pend <= 1'b1;
      if (w_ctrl_rd || w_start) begin
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end
      if (w_start && (w_len == '0)) r_done <= 1'b1;
      if (w_enter_rel) begin
        if (w_abort) r_aborted <= 1'b1;
        else         r_done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_dma_master.sv
// Directed bench for mem_dma_master: register table plus copy/fill/abort/stall/reset sequences.
module tb_mem_dma_master;
  import mem_dma_master_pkg::*;

  localparam logic [15:0] BASE = 16'hFD10;

  logic        e = 1'b0;
  logic        _reset;
  logic [15:0] address_cpu;
  logic        r_w_cpu;
  logic [7:0]  data_cpu_in;
  logic [7:0]  data_cpu_out;
  logic        cpu_sel;
  logic        _halt;
  logic        ba = 1'b0;
  logic        mem_busy;
  logic [20:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        _mem_we;
  logic        irq;

  logic        ba_block = 1'b0;
  logic [7:0]  wmem [0:255];
  int          wcount = 0;
  int          bcount = 0;
  int          hcount = 0;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    logic       wr;
    logic [3:0] off;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [24];

  mem_dma_master dut (
    .e            (e),
    ._reset       (_reset),
    .address_cpu  (address_cpu),
    .r_w_cpu      (r_w_cpu),
    .data_cpu_in  (data_cpu_in),
    .data_cpu_out (data_cpu_out),
    .cpu_sel      (cpu_sel),
    ._halt        (_halt),
    .ba           (ba),
    .mem_busy     (mem_busy),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    ._mem_we      (_mem_we),
    .irq          (irq)
  );

  always #5 e = ~e;

  // SRAM read data is a fixed function of address; writes land in a sparse shadow
  assign mem_din = mem_addr[7:0] ^ 8'h5A;

  function automatic logic [7:0] widx(input logic [20:0] a);
    return {a[17:16], a[5:0]};
  endfunction

  // CPU grants the bus one cycle after _halt falls unless the test blocks it
  always @(posedge e) begin
    ba <= ~_halt & ~ba_block;
    if (mem_busy && !_mem_we) begin
      wmem[widx(mem_addr)] <= mem_dout;
      wcount <= wcount + 1;
    end
    if (mem_busy) bcount <= bcount + 1;
    if (!_halt)   hcount <= hcount + 1;
  end

  task automatic tick();
    @(posedge e);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] off, input logic [7:0] d);
    address_cpu = BASE + 16'(off);
    r_w_cpu     = 1'b0;
    data_cpu_in = d;
    tick();
    address_cpu = 16'h0000;
    r_w_cpu     = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [7:0] exp);
    address_cpu = BASE + 16'(off);
    r_w_cpu     = 1'b1;
    #1;
    chk(name, 32'(data_cpu_out), 32'(exp));
    tick();
    address_cpu = 16'h0000;
  endtask

  task automatic set_xfer(input logic [20:0] src, input logic [20:0] dst, input logic [15:0] len);
    cpu_wr(DMA_SRC_L, src[7:0]);
    cpu_wr(DMA_SRC_M, src[15:8]);
    cpu_wr(DMA_SRC_H, 8'(src[20:16]));
    cpu_wr(DMA_DST_L, dst[7:0]);
    cpu_wr(DMA_DST_M, dst[15:8]);
    cpu_wr(DMA_DST_H, 8'(dst[20:16]));
    cpu_wr(DMA_LEN_L, len[7:0]);
    cpu_wr(DMA_LEN_H, len[15:8]);
  endtask

  task automatic wait_idle(input string name, input int max);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (_halt && !mem_busy) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    chk({name, "_finished"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   w0, b0, h0;
    logic found;

    _reset      = 1'b0;
    address_cpu = 16'h0000;
    r_w_cpu     = 1'b1;
    data_cpu_in = 8'h00;

    vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'h8, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 4'hF, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 4'h0, 8'h34, 8'h00};
    vecs[4]  = '{1'b1, 4'h1, 8'h12, 8'h00};
    vecs[5]  = '{1'b1, 4'h2, 8'hFF, 8'h00};
    vecs[6]  = '{1'b0, 4'h0, 8'h00, 8'h34};
    vecs[7]  = '{1'b0, 4'h1, 8'h00, 8'h12};
    vecs[8]  = '{1'b0, 4'h2, 8'h00, 8'h1F};
    vecs[9]  = '{1'b1, 4'h3, 8'h77, 8'h00};
    vecs[10] = '{1'b1, 4'h5, 8'hE3, 8'h00};
    vecs[11] = '{1'b0, 4'h3, 8'h00, 8'h77};
    vecs[12] = '{1'b0, 4'h5, 8'h00, 8'h03};
    vecs[13] = '{1'b1, 4'h6, 8'hCD, 8'h00};
    vecs[14] = '{1'b1, 4'h7, 8'hAB, 8'h00};
    vecs[15] = '{1'b0, 4'h6, 8'h00, 8'hCD};
    vecs[16] = '{1'b0, 4'h7, 8'h00, 8'hAB};
    vecs[17] = '{1'b1, 4'h8, 8'h06, 8'h00};
    vecs[18] = '{1'b0, 4'h8, 8'h00, 8'h06};
    vecs[19] = '{1'b1, 4'h9, 8'h55, 8'h00};
    vecs[20] = '{1'b0, 4'h9, 8'h00, 8'h00};
    vecs[21] = '{1'b1, 4'h8, 8'h00, 8'h00};
    vecs[22] = '{1'b0, 4'h8, 8'h00, 8'h00};
    vecs[23] = '{1'b0, 4'h4, 8'h00, 8'h00};

    repeat (2) @(posedge e);
    #1;
    chk("rst_halt",   32'(_halt),        32'd1);
    chk("rst_busy",   32'(mem_busy),     32'd0);
    chk("rst_we",     32'(_mem_we),      32'd1);
    chk("rst_addr",   32'(mem_addr),     32'd0);
    chk("rst_dout",   32'(mem_dout),     32'd0);
    chk("rst_irq",    32'(irq),          32'd0);
    chk("rst_rdata",  32'(data_cpu_out), 32'd0);
    chk("rst_sel",    32'(cpu_sel),      32'd0);
    _reset = 1'b1;
    tick();

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].wr) begin
        cpu_wr(vecs[i].off, vecs[i].wdata);
      end else begin
        address_cpu = BASE + 16'(vecs[i].off);
        r_w_cpu     = 1'b1;
        #1;
        chk($sformatf("vec%0d_data", i), 32'(data_cpu_out), 32'(vecs[i].exp));
        chk($sformatf("vec%0d_sel", i),  32'(cpu_sel),      32'd1);
        tick();
        address_cpu = 16'h0000;
      end
    end

    address_cpu = 16'hFD20;
    r_w_cpu     = 1'b1;
    #1;
    chk("miss_sel",   32'(cpu_sel),      32'd0);
    chk("miss_rdata", 32'(data_cpu_out), 32'd0);
    tick();
    address_cpu = 16'h0000;

    // copy four bytes
    set_xfer(21'h010000, 21'h020000, 16'd4);
    w0 = wcount; b0 = bcount; h0 = hcount;
    cpu_wr(DMA_CTRL, 8'h01);
    chk("req_halt", 32'(_halt),    32'd0);
    chk("req_busy", 32'(mem_busy), 32'd0);
    wait_idle("copy", 40);
    chk("copy_writes", 32'(wcount - w0), 32'd4);
    chk("copy_busy",   32'(bcount - b0), 32'd8);
    chk("copy_halt",   32'(hcount - h0), 32'd10);
    for (int i = 0; i < 4; i++)
      chk($sformatf("copy_byte%0d", i), 32'(wmem[8'h80 + 8'(i)]), 32'(8'(i) ^ 8'h5A));
    chk("copy_irq", 32'(irq), 32'd0);
    rd_chk("copy_src_l", DMA_SRC_L, 8'h04);
    rd_chk("copy_src_h", DMA_SRC_H, 8'h01);
    rd_chk("copy_len_l", DMA_LEN_L, 8'h00);
    rd_chk("copy_dst_l", DMA_DST_L, 8'h04);
    rd_chk("copy_ctrl",  DMA_CTRL,  8'h40);
    rd_chk("copy_ctrl2", DMA_CTRL,  8'h00);

    // fill across the top of the address space
    cpu_wr(DMA_SRC_L, 8'hA5);
    cpu_wr(DMA_DST_L, 8'hFE);
    cpu_wr(DMA_DST_M, 8'hFF);
    cpu_wr(DMA_DST_H, 8'h1F);
    cpu_wr(DMA_LEN_L, 8'h03);
    cpu_wr(DMA_LEN_H, 8'h00);
    w0 = wcount; b0 = bcount;
    cpu_wr(DMA_CTRL, 8'h07);
    wait_idle("fill", 40);
    chk("fill_writes", 32'(wcount - w0), 32'd3);
    chk("fill_busy",   32'(bcount - b0), 32'd3);
    chk("fill_1ffffe", 32'(wmem[8'hFE]), 32'hA5);
    chk("fill_1fffff", 32'(wmem[8'hFF]), 32'hA5);
    chk("fill_000000", 32'(wmem[8'h00]), 32'hA5);
    chk("fill_irq",    32'(irq),         32'd1);
    rd_chk("fill_dst_l", DMA_DST_L, 8'h01);
    rd_chk("fill_dst_h", DMA_DST_H, 8'h00);
    rd_chk("fill_src_l", DMA_SRC_L, 8'hA5);
    rd_chk("fill_ctrl",  DMA_CTRL,  8'h46);
    chk("fill_irq_clr", 32'(irq), 32'd0);

    // zero length completes without requesting the bus
    cpu_wr(DMA_CTRL, 8'h00);
    cpu_wr(DMA_LEN_L, 8'h00);
    cpu_wr(DMA_LEN_H, 8'h00);
    w0 = wcount; h0 = hcount;
    cpu_wr(DMA_CTRL, 8'h01);
    chk("len0_halt", 32'(_halt), 32'd1);
    rd_chk("len0_ctrl", DMA_CTRL, 8'h40);
    tick();
    chk("len0_nohalt",  32'(hcount - h0), 32'd0);
    chk("len0_nowrite", 32'(wcount - w0), 32'd0);

    // bus grant withheld: engine must wait in REQ
    set_xfer(21'h010008, 21'h020010, 16'd2);
    ba_block = 1'b1;
    w0 = wcount;
    cpu_wr(DMA_CTRL, 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bawait_busy%0d", i), 32'(mem_busy), 32'd0);
      chk($sformatf("bawait_halt%0d", i), 32'(_halt),    32'd0);
    end
    rd_chk("bawait_ctrl", DMA_CTRL, 8'h80);
    chk("bawait_nowrite", 32'(wcount - w0), 32'd0);
    ba_block = 1'b0;
    wait_idle("bawait", 40);
    chk("bawait_writes", 32'(wcount - w0), 32'd2);
    chk("bawait_byte0",  32'(wmem[8'h90]), 32'h52);
    chk("bawait_byte1",  32'(wmem[8'h91]), 32'h53);

    // abort after two of ten bytes
    set_xfer(21'h010020, 21'h020020, 16'd10);
    w0 = wcount;
    cpu_wr(DMA_CTRL, 8'h01);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wcount - w0 == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_reach2", 32'(found), 32'd1);
    cpu_wr(DMA_CTRL, 8'h08);
    chk("abort_halt", 32'(_halt),    32'd1);
    chk("abort_busy", 32'(mem_busy), 32'd0);
    tick();
    chk("abort_writes", 32'(wcount - w0), 32'd2);
    rd_chk("abort_len_l", DMA_LEN_L, 8'h08);
    rd_chk("abort_src_l", DMA_SRC_L, 8'h22);
    rd_chk("abort_ctrl",  DMA_CTRL,  8'h20);
    rd_chk("abort_ctrl2", DMA_CTRL,  8'h00);

    // asynchronous reset in the middle of a write cycle
    set_xfer(21'h010030, 21'h020030, 16'd4);
    cpu_wr(DMA_CTRL, 8'h01);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!_mem_we) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstwr_reach", 32'(found), 32'd1);
    #2;
    _reset = 1'b0;
    #1;
    chk("rstwr_we",   32'(_mem_we),  32'd1);
    chk("rstwr_halt", 32'(_halt),    32'd1);
    chk("rstwr_busy", 32'(mem_busy), 32'd0);
    w0 = wcount;
    tick();
    tick();
    chk("rstwr_nowrite", 32'(wcount - w0), 32'd0);
    _reset = 1'b1;
    tick();
    rd_chk("rstwr_src_l", DMA_SRC_L, 8'h00);
    rd_chk("rstwr_dst_l", DMA_DST_L, 8'h00);
    rd_chk("rstwr_len_l", DMA_LEN_L, 8'h00);
    rd_chk("rstwr_ctrl",  DMA_CTRL,  8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
